// File: rtl/edge_gen_if.sv
// edge_gen_if: request/pulse bundle between a trigger source and edge_gen.
//   trig  requester -> generator   one pulse request per cycle while high
//   o     generator -> requester   registered pulse train
//   busy  generator -> requester   generator is not idle
//   pend  generator -> requester   queued requests not yet started
//   drop  generator -> requester   one-cycle strobe, a request was lost
interface edge_gen_if #(
    parameter int PEND_W = 3
);
    logic              trig;
    logic              o;
    logic              busy;
    logic [PEND_W-1:0] pend;
    logic              drop;

    modport master (
        output trig,
        input  o,
        input  busy,
        input  pend,
        input  drop
    );

    modport slave (
        input  trig,
        output o,
        output busy,
        output pend,
        output drop
    );
endinterface

// File: rtl/edge_gen.sv
// edge_gen: turns single-cycle trigger requests into clean pulses on a level
// output, one pulse per request, with fixed active width and a minimum idle gap.
// Requests arriving while a pulse is in flight are queued and replayed
// back-to-back at a pitch of ACTIVE_CYCLES+IDLE_CYCLES; requests beyond the
// queue depth are dropped and flagged.
// Ports:
//   clk     system clock, all logic on posedge
//   resetn  asynchronous active-low reset
//   bus     edge_gen_if slave: trig in; o, busy, pend, drop out
module edge_gen #(
    parameter int TYPE          = 0,  // 0: idle high/active low, 1: idle low/active high
    parameter int ACTIVE_CYCLES = 4,
    parameter int IDLE_CYCLES   = 4,
    parameter int PEND_W        = 3
) (
    input  logic       clk,
    input  logic       resetn,
    edge_gen_if.slave  bus
);
    localparam int MAXC  = (ACTIVE_CYCLES > IDLE_CYCLES) ? ACTIVE_CYCLES : IDLE_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [CNT_W-1:0]  A_LOAD   = CNT_W'(ACTIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  I_LOAD   = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PEND_W:0]   P_ONE    = (PEND_W+1)'(1);
    localparam logic [PEND_W:0]   PEND_MAX = {1'b0, {PEND_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              o_q, o_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;

    // Queue arithmetic is one bit wider than the port so a saturated
    // increment can be detected without wrapping.
    logic [PEND_W:0]   pend_w;
    logic [PEND_W:0]   e_w;
    logic              enq;

    logic              act_lvl;
    logic              idle_lvl;

    generate
        if (TYPE != 0) begin : g_act_high
            assign act_lvl = 1'b1;
        end else begin : g_act_low
            assign act_lvl = 1'b0;
        end
    endgenerate

    assign idle_lvl = ~act_lvl;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            o_q     <= idle_lvl;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        drop_d  = 1'b0;
        enq     = 1'b0;
        pend_w  = {1'b0, pend_q};
        // Requests available at the end of a recovery gap: queued plus this cycle's.
        e_w     = {1'b0, pend_q} + {{PEND_W{1'b0}}, bus.trig};

        case (state_q)
            S_IDLE: begin
                if (bus.trig) begin
                    state_d = S_ACTIVE;
                    o_d     = act_lvl;
                    cnt_d   = A_LOAD;
                end
            end
            S_ACTIVE: begin
                enq = bus.trig;
                if (cnt_q == '0) begin
                    state_d = S_RECOVER;
                    o_d     = idle_lvl;
                    cnt_d   = I_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RECOVER: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                    enq   = bus.trig;
                end else if (e_w != '0) begin
                    // Dequeue one and start immediately; a same-cycle request
                    // is absorbed into e_w so it can never overflow here.
                    state_d = S_ACTIVE;
                    o_d     = act_lvl;
                    cnt_d   = A_LOAD;
                    pend_w  = e_w - P_ONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                o_d     = idle_lvl;
                cnt_d   = '0;
            end
        endcase

        if (enq) begin
            if (pend_w == PEND_MAX) begin
                drop_d = 1'b1;
            end else begin
                pend_w = pend_w + P_ONE;
            end
        end

        busy_d = (state_d != S_IDLE);
        pend_d = pend_w[PEND_W-1:0];
    end

    assign bus.o    = o_q;
    assign bus.busy = busy_q;
    assign bus.pend = pend_q;
    assign bus.drop = drop_q;
endmodule

// File: tb/tb_edge_gen.sv
// tb_edge_gen: three edge_gen instances with different parameter sets share a
// clock and reset. A timeline model (pulse start times plus a request count)
// predicts o/busy/pend/drop for each instance and is compared on every falling
// clock edge; directed sequences add literal expectations.
//   inst 0: TYPE=1 A=3 I=2 PEND_W=3
//   inst 1: TYPE=0 A=3 I=2 PEND_W=3
//   inst 2: TYPE=0 A=4 I=4 PEND_W=2
module tb_edge_gen;
    localparam int P_TYPE [3] = '{1, 0, 0};
    localparam int P_A    [3] = '{3, 3, 4};
    localparam int P_I    [3] = '{2, 2, 4};
    localparam int P_PMAX [3] = '{7, 7, 3};

    logic clk;
    logic resetn;
    logic trig_v [3];

    int checks = 0;
    int errors = 0;

    edge_gen_if #(.PEND_W(3)) if0 ();
    edge_gen_if #(.PEND_W(3)) if1 ();
    edge_gen_if #(.PEND_W(2)) if2 ();

    edge_gen #(.TYPE(1), .ACTIVE_CYCLES(3), .IDLE_CYCLES(2), .PEND_W(3)) u0 (
        .clk(clk), .resetn(resetn), .bus(if0.slave));
    edge_gen #(.TYPE(0), .ACTIVE_CYCLES(3), .IDLE_CYCLES(2), .PEND_W(3)) u1 (
        .clk(clk), .resetn(resetn), .bus(if1.slave));
    edge_gen #(.TYPE(0), .ACTIVE_CYCLES(4), .IDLE_CYCLES(4), .PEND_W(2)) u2 (
        .clk(clk), .resetn(resetn), .bus(if2.slave));

    assign if0.trig = trig_v[0];
    assign if1.trig = trig_v[1];
    assign if2.trig = trig_v[2];

    logic       dut_o    [3];
    logic       dut_busy [3];
    logic       dut_drop [3];
    logic [3:0] dut_pend [3];

    assign dut_o[0] = if0.o;  assign dut_busy[0] = if0.busy;
    assign dut_o[1] = if1.o;  assign dut_busy[1] = if1.busy;
    assign dut_o[2] = if2.o;  assign dut_busy[2] = if2.busy;
    assign dut_drop[0] = if0.drop;
    assign dut_drop[1] = if1.drop;
    assign dut_drop[2] = if2.drop;
    assign dut_pend[0] = {1'b0, if0.pend};
    assign dut_pend[1] = {1'b0, if1.pend};
    assign dut_pend[2] = {2'b0, if2.pend};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Timeline model: a pulse started at edge s is active after edges s..s+A-1
    // and blocks new starts until edge s+A+I. A request arriving while blocked
    // is queued (or dropped when the queue is full); at the first free edge the
    // queue plus any same-edge request may start one pulse.
    int t_now = 0;
    bit m_started [3] = '{0, 0, 0};
    int m_last    [3] = '{0, 0, 0};
    int m_pend    [3] = '{0, 0, 0};
    bit m_drop    [3] = '{0, 0, 0};

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) begin
                m_started[i] = 1'b0;
                m_pend[i]    = 0;
                m_drop[i]    = 1'b0;
            end
        end else begin
            t_now++;
            for (int i = 0; i < 3; i++) begin
                int e;
                m_drop[i] = 1'b0;
                if (!m_started[i] || (t_now - m_last[i] >= P_A[i] + P_I[i])) begin
                    e = m_pend[i] + (trig_v[i] ? 1 : 0);
                    if (e > 0) begin
                        m_started[i] = 1'b1;
                        m_last[i]    = t_now;
                        m_pend[i]    = e - 1;
                    end
                end else if (trig_v[i]) begin
                    if (m_pend[i] == P_PMAX[i]) m_drop[i] = 1'b1;
                    else                         m_pend[i]++;
                end
            end
        end
    end

    // Leading-edge counters play the part of a far-end edge_detect.
    int edges    [3] = '{0, 0, 0};
    bit prev_o   [3] = '{0, 1, 1};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int exp_o;
            int exp_busy;
            exp_o    = (m_started[i] && (t_now - m_last[i] < P_A[i])) ? P_TYPE[i] : 1 - P_TYPE[i];
            exp_busy = (m_started[i] && (t_now - m_last[i] < P_A[i] + P_I[i])) ? 1 : 0;
            chk($sformatf("m%0d_o", i),    int'(dut_o[i]),    exp_o);
            chk($sformatf("m%0d_busy", i), int'(dut_busy[i]), exp_busy);
            chk($sformatf("m%0d_pend", i), int'(dut_pend[i]), m_pend[i]);
            chk($sformatf("m%0d_drop", i), int'(dut_drop[i]), int'(m_drop[i]));
            if (int'(dut_o[i]) == P_TYPE[i] && int'(prev_o[i]) != P_TYPE[i]) edges[i]++;
            prev_o[i] = dut_o[i];
        end
    end

    int e2o [6]  = '{1, 1, 1, 0, 0, 0};
    int e2b [6]  = '{1, 1, 1, 1, 1, 0};
    int e3o [16] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1};
    int e3p [16] = '{0, 1, 2, 2, 2, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};

    initial begin
        int ndrop;
        int exp_p;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) trig_v[i] = 1'b0;
        #1 resetn = 1'b0;

        // Reset held while triggers toggle: outputs stay at idle values.
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 3; i++) trig_v[i] = (j % 2 == 0);
            tick();
            chk("rst_o0", int'(dut_o[0]), 0);
            chk("rst_o1", int'(dut_o[1]), 1);
            chk("rst_busy0", int'(dut_busy[0]), 0);
            chk("rst_pend1", int'(dut_pend[1]), 0);
            chk("rst_drop2", int'(dut_drop[2]), 0);
        end
        for (int i = 0; i < 3; i++) trig_v[i] = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        tick();

        // Single request, active-high: high for 3 edges, busy for 5.
        trig_v[0] = 1'b1;
        tick();
        trig_v[0] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("t2_o_k%0d", j),    int'(dut_o[0]),    e2o[j]);
            chk($sformatf("t2_busy_k%0d", j), int'(dut_busy[0]), e2b[j]);
            tick();
        end
        chk("t2_edges", edges[0], 1);

        // Three consecutive requests, active-low: pulses at k, k+5, k+10.
        trig_v[1] = 1'b1;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (j == 2) trig_v[1] = 1'b0;
            chk($sformatf("t3_o_k%0d", j),    int'(dut_o[1]),    e3o[j]);
            chk($sformatf("t3_pend_k%0d", j), int'(dut_pend[1]), e3p[j]);
        end
        chk("t3_busy_end", int'(dut_busy[1]), 0);
        chk("t3_edges", edges[1], 3);

        // Six requests into a depth-3 queue: one starts, three queue, two drop.
        ndrop = 0;
        trig_v[2] = 1'b1;
        for (int j = 0; j < 33; j++) begin
            tick();
            if (j == 5) trig_v[2] = 1'b0;
            if (j == 0)      exp_p = 0;
            else if (j < 3)  exp_p = j;
            else if (j < 8)  exp_p = 3;
            else if (j < 16) exp_p = 2;
            else if (j < 24) exp_p = 1;
            else             exp_p = 0;
            chk($sformatf("t4_pend_k%0d", j), int'(dut_pend[2]), exp_p);
            chk($sformatf("t4_drop_k%0d", j), int'(dut_drop[2]), (j == 4 || j == 5) ? 1 : 0);
            chk($sformatf("t4_o_k%0d", j),    int'(dut_o[2]),    (j < 32 && (j % 8) < 4) ? 0 : 1);
            chk($sformatf("t4_busy_k%0d", j), int'(dut_busy[2]), (j < 32) ? 1 : 0);
            if (dut_drop[2]) ndrop++;
        end
        chk("t4_ndrop", ndrop, 2);
        chk("t4_edges", edges[2], 4);

        // Request on the last recovery cycle restarts with no gap and no queueing.
        trig_v[0] = 1'b1;
        tick();
        trig_v[0] = 1'b0;
        for (int j = 1; j < 5; j++) tick();
        chk("t5_o_last_recover", int'(dut_o[0]), 0);
        trig_v[0] = 1'b1;
        tick();
        trig_v[0] = 1'b0;
        chk("t5_o_restart",    int'(dut_o[0]),    1);
        chk("t5_pend_restart", int'(dut_pend[0]), 0);
        chk("t5_busy_restart", int'(dut_busy[0]), 1);
        for (int j = 0; j < 6; j++) tick();
        chk("t5_edges", edges[0], 3);

        // Reset during a pulse with two queued: idle at once, queue discarded.
        trig_v[1] = 1'b1;
        tick();
        tick();
        tick();
        trig_v[1] = 1'b0;
        chk("t6_pend_before", int'(dut_pend[1]), 2);
        chk("t6_o_before",    int'(dut_o[1]),    0);
        resetn = 1'b0;
        #1;
        chk("t6_o_async",    int'(dut_o[1]),    1);
        chk("t6_pend_async", int'(dut_pend[1]), 0);
        chk("t6_busy_async", int'(dut_busy[1]), 0);
        tick();
        tick();
        resetn = 1'b1;
        for (int j = 0; j < 12; j++) tick();
        chk("t6_edges", edges[1], 4);
        chk("t6_o_after",    int'(dut_o[1]),    1);
        chk("t6_busy_after", int'(dut_busy[1]), 0);

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
